ring_nic: RTL

//  Network interface between one processor port and one ring router inside the interconnect top.

---
 rtl/ring_nic_pkg.sv | 30 +++
 rtl/ring_nic_fifo.sv | 63 ++++++
 rtl/ring_nic.sv | 115 +++++++++++
 3 files changed

// File: rtl/ring_nic_pkg.sv
// ring_nic_pkg: shared constants and types for the ring network interface.
//   PKT_W        : packet width
//   field bits   : VC, direction, hop count, source id and payload positions
//   nic_addr_e   : processor-side register map addresses
//   pkt_vc()     : extracts the virtual-channel bit of a packet
package ring_nic_pkg;

  localparam int PKT_W   = 64;

  localparam int VC_BIT  = 63;
  localparam int DIR_BIT = 62;
  localparam int HOP_HI  = 55;
  localparam int HOP_LO  = 48;
  localparam int SRC_HI  = 47;
  localparam int SRC_LO  = 32;
  localparam int DATA_HI = 31;
  localparam int DATA_LO = 0;

  typedef enum logic [1:0] {
    ADDR_IN_BUF   = 2'b00,
    ADDR_IN_STAT  = 2'b01,
    ADDR_OUT_BUF  = 2'b10,
    ADDR_OUT_STAT = 2'b11
  } nic_addr_e;

  function automatic logic pkt_vc(input logic [PKT_W-1:0] pkt);
    return pkt[VC_BIT];
  endfunction

endpackage

// File: rtl/ring_nic_fifo.sv
// ring_nic_fifo: small synchronous FIFO used for both NIC directions.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push/din : write request and data; ignored when full (pre-edge state)
//   pop      : read request; ignored when empty
//   head     : current head entry (valid while ~empty)
//   full     : count == DEPTH
//   empty    : count == 0
module ring_nic_fifo #(
  parameter int DEPTH = 2,
  parameter int PKT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [PKT_W-1:0] din,
  output logic [PKT_W-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_FW = $clog2(DEPTH) + 1;

  logic [PKT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_FW-1:0] count;
  logic              do_push;
  logic              do_pop;

  // Explicit wrap keeps this correct for DEPTH=1, where the pointer never moves.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_FW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ring_nic.sv
// ring_nic: network interface between one processor port and one ring router.
//   clk, rst              : clock, synchronous active-high reset
//   addr/d_in/nicEN/nicWrEn : processor register-map access
//   d_out                 : registered read data (zero when no read)
//   net_si/net_ri/net_di  : router -> NIC ingress channel
//   net_so/net_ro/net_do  : NIC -> router egress channel, gated by ring polarity
//   net_polarity          : current ring phase; a packet leaves only when its VC bit matches
//   tx_cnt/rx_cnt/drop_cnt: statistics
// Build option: NIC_STATS_EN enables saturating statistics counters; when
// undefined the counter ports are tied to zero.
module ring_nic
  import ring_nic_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       addr,
  input  logic [PKT_W-1:0] d_in,
  input  logic             nicEN,
  input  logic             nicWrEn,
  output logic [PKT_W-1:0] d_out,
  input  logic             net_si,
  output logic             net_ri,
  input  logic [PKT_W-1:0] net_di,
  output logic             net_so,
  input  logic             net_ro,
  output logic [PKT_W-1:0] net_do,
  input  logic             net_polarity,
  output logic [CNT_W-1:0] tx_cnt,
  output logic [CNT_W-1:0] rx_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  logic             rd_strobe;
  logic             out_wr;
  logic             in_push;
  logic             in_pop;
  logic [PKT_W-1:0] in_head;
  logic             in_full;
  logic             in_empty;
  logic             out_full;
  logic             out_empty;

  assign rd_strobe = nicEN & ~nicWrEn;
  assign out_wr    = nicEN & nicWrEn & (addr == ADDR_OUT_BUF);
  assign in_pop    = rd_strobe & (addr == ADDR_IN_BUF);

  assign net_ri  = ~in_full;
  assign in_push = net_si & net_ri;

  // Head-of-line: only the head packet is considered, so order is preserved
  // even if a later packet would match the current phase.
  assign net_so = ~out_empty & net_ro & (pkt_vc(net_do) == net_polarity);

  ring_nic_fifo #(.DEPTH(DEPTH), .PKT_W(PKT_W)) u_in_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_push),
    .pop   (in_pop),
    .din   (net_di),
    .head  (in_head),
    .full  (in_full),
    .empty (in_empty)
  );

  ring_nic_fifo #(.DEPTH(DEPTH), .PKT_W(PKT_W)) u_out_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (out_wr),
    .pop   (net_so),
    .din   (d_in),
    .head  (net_do),
    .full  (out_full),
    .empty (out_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      d_out <= '0;
    end else if (rd_strobe) begin
      case (addr)
        ADDR_IN_BUF:   d_out <= in_empty ? '0 : in_head;
        ADDR_IN_STAT:  d_out <= {{(PKT_W-2){1'b0}}, in_full, ~in_empty};
        ADDR_OUT_STAT: d_out <= {{(PKT_W-2){1'b0}}, out_empty, out_full};
        default:       d_out <= '0;
      endcase
    end else begin
      d_out <= '0;
    end
  end

`ifdef NIC_STATS_EN
  logic drop_ev;
  assign drop_ev = out_wr & out_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_cnt   <= '0;
      rx_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      if (net_so  && tx_cnt   != '1) tx_cnt   <= tx_cnt + 1'b1;
      if (in_push && rx_cnt   != '1) rx_cnt   <= rx_cnt + 1'b1;
      if (drop_ev && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end
`else
  assign tx_cnt   = '0;
  assign rx_cnt   = '0;
  assign drop_cnt = '0;
`endif

endmodule
